// File: rtl/mat_tx_serializer.sv
// Captures a flattened result matrix and streams it byte by byte to a UART
// transmitter over a start/busy handshake, with optional header and checksum.
module mat_tx_serializer #(
  parameter int                N_CELLS       = 9,
  parameter int                DATA_W        = 8,
  parameter int                SEND_HEADER   = 1,
  parameter logic [DATA_W-1:0] HEADER        = 8'hA5,
  parameter int                SEND_CHECKSUM = 1,
  parameter int                ACK_TIMEOUT   = 4095
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [N_CELLS*DATA_W-1:0]   i_mat,
  input  logic                        i_tx_busy,
  output logic [DATA_W-1:0]           o_tx_data,
  output logic                        o_tx_start,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err
);

  localparam int L     = N_CELLS + SEND_HEADER + SEND_CHECKSUM;
  localparam int IDX_W = $clog2(L + 1);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                      r_state, w_next;
  logic [N_CELLS*DATA_W-1:0]   r_shadow;
  logic [IDX_W-1:0]            r_idx;
  logic [DATA_W-1:0]           r_acc;
  logic [DATA_W-1:0]           r_tx_data;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_err;
  logic                        r_busy_m, r_busy_s;
  logic [DATA_W-1:0]           w_byte;
  logic                        w_is_cell;
  logic                        w_last;
  logic                        w_timeout;

  assign w_last    = (r_idx == IDX_W'(L - 1));
  assign w_timeout = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

  // Byte selector: header slot, then cells, then the running checksum.
  always_comb begin
    int c;
    c         = int'(r_idx) - SEND_HEADER;
    w_byte    = r_acc;
    w_is_cell = 1'b0;
    if (SEND_HEADER != 0 && r_idx == '0) begin
      w_byte = HEADER;
    end else if (c >= 0 && c < N_CELLS) begin
      w_byte    = r_shadow[c*DATA_W +: DATA_W];
      w_is_cell = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_LOAD;
      S_LOAD: w_next = S_REQ;
      S_REQ: begin
        if (r_busy_s)       w_next = S_WAIT;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_WAIT: if (!r_busy_s) w_next = w_last ? S_DONE : S_LOAD;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_tx_data  = r_tx_data;
    o_tx_start = (r_state == S_REQ);
    o_busy     = (r_state != S_IDLE);
    o_done     = (r_state == S_DONE);
    o_err      = r_err;
  end

  // Datapath: busy synchronizer, shadow capture, byte index, checksum, timeout.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_busy_m  <= 1'b0;
      r_busy_s  <= 1'b0;
      r_shadow  <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      r_tx_data <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_busy_m <= i_tx_busy;
      r_busy_s <= r_busy_m;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_shadow <= i_mat;
            r_idx    <= '0;
            r_acc    <= '0;
          end
        end
        S_LOAD: begin
          r_tx_data <= w_byte;
          if (w_is_cell) r_acc <= r_acc + w_byte;
          r_cnt <= '0;
        end
        S_REQ: begin
          if (!r_busy_s) begin
            if (w_timeout) r_err <= 1'b1;
            else           r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (!r_busy_s && !w_last) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mat_tx_serializer.md
Name: mat_tx_serializer

Overview:
- Sits between the matrix multiplier and the UART transmitter.
- Captures the 3x3 result matrix when the multiplier signals ready.
- Sends it one byte at a time over a start/busy handshake with the transmitter, which runs in the slower baud clock domain.
- Frame format: optional header byte, then 9 cells in row-major order, then an optional mod-256 checksum.

Parameters:
- N_CELLS, 9, number of matrix cells per frame.
- DATA_W, 8, bits per cell (equals the UART byte width).
- SEND_HEADER, 1, when 1, prepend the HEADER byte to each frame.
- HEADER, 8'hA5, value of the header byte.
- SEND_CHECKSUM, 1, when 1, append the checksum byte to each frame.
- ACK_TIMEOUT, 4095, maximum i_clk cycles to wait for synchronized busy to rise after asserting o_tx_start.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; asynchronous, active-low.
- i_start  in  1  one-cycle pulse when the result is ready (the multiplier's ready output).
- i_mat  in  N_CELLS*DATA_W  flattened result; cell k occupies bits [k*DATA_W +: DATA_W]; cell 0 = row 0, column 0.
- i_tx_busy  in  1  transmitter busy flag, asynchronous to i_clk.
- o_tx_data  out  DATA_W  byte presented to the transmitter.
- o_tx_start  out  1  level request to the transmitter.
- o_busy  out  1  high from frame capture until the frame ends.
- o_done  out  1  one-cycle pulse after the last byte completes.
- o_err  out  1  sticky; set on ack timeout.

Behaviour:
- Reset (i_rst low, asynchronous):
  - State = IDLE.
  - o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0, o_err=0.
  - Synchronizer flops, byte index and checksum accumulator = 0.
- Busy synchronizer: i_tx_busy passes through 2 flops to give busy_s. Only busy_s is used internally.
- Frame length L = N_CELLS + SEND_HEADER + SEND_CHECKSUM (11 with defaults).
- Byte order:
  - header (if SEND_HEADER), then cells 0..N_CELLS-1, then checksum (if SEND_CHECKSUM).
  - Checksum = sum mod 256 of the cell bytes only; the header is excluded.
- IDLE:
  - On i_start=1: register all of i_mat into an internal shadow.
  - Set o_busy=1 on the next edge; index=0; accumulator=0; go to LOAD.
  - i_start while not in IDLE is ignored; no queueing. The shadow is not disturbed.
- LOAD:
  - o_tx_data <= byte[index]; if the byte is a cell, add it to the accumulator.
  - o_tx_start <= 1; clear the timeout counter; go to REQ.
- REQ:
  - Hold o_tx_start=1 and o_tx_data stable.
  - On busy_s=1: o_tx_start <= 0; go to WAIT.
  - If the counter reaches ACK_TIMEOUT first: o_err <= 1, o_tx_start <= 0, o_busy <= 0; go to IDLE, abandoning the frame.
- WAIT:
  - On busy_s=0: if index = L-1, go to DONE; else index+1 and go to LOAD.
  - o_tx_data stays stable until the next LOAD.
- DONE:
  - o_done=1 for exactly one cycle; o_busy <= 0; go to IDLE.
- Busy already high on entry to REQ (stale busy from a previous frame): treated as an ack. The transmitter must drop busy between bytes, so WAIT still sequences correctly.
- o_err is cleared only by reset. A new i_start after an error is accepted normally.
- Reset asserted mid-frame: immediate abort to reset values; no partial byte is retried.
- Minimum i_clk cycles per byte: LOAD + 2 sync cycles + REQ + WAIT.

Test Plan:
- Defaults; i_mat cells = 1..9; transmitter model raises busy 3 cycles after start and holds it 20 cycles -> bytes A5,01,02,03,04,05,06,07,08,09,2D in order; o_done pulses once; o_busy high throughout; o_err=0.
- i_mat all 8'hFF, SEND_HEADER=0 -> 9×FF then checksum F7; frame length 10.
- Second i_start pulse mid-frame with different data -> transmitted bytes still match the first capture; no second frame follows.
- Transmitter never asserts busy, ACK_TIMEOUT=15 -> o_err=1 after 15 cycles in REQ; o_tx_start=0; o_busy=0; next i_start sends a full frame with o_err still 1.
- i_rst pulsed low during byte 5 -> outputs go to 0 immediately, asynchronously; next i_start restarts at the header byte.
- Busy stuck high for 100 cycles before i_start -> first byte held in WAIT until busy falls; all bytes still delivered in order.
